// File: rtl/demux_slot_counter.sv
// demux_slot_counter: E1 bit/slot/frame position counter with startup fill skip; DEMUX_MULTIFRAME_EN adds CRC-4 multiframe index
module demux_slot_counter #(
    parameter int BITS_PER_SLOT = 8,
    parameter int NUM_SLOTS     = 32,
    parameter int STARTUP_BITS  = 8,
    parameter int BYTE_CNT_W    = 8,
    localparam int BIT_W  = $clog2(BITS_PER_SLOT),
    localparam int SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  bit_en,
    input  logic                  realign,
    output logic [BIT_W-1:0]      bit_idx,
    output logic [SLOT_W-1:0]     slot_idx,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic                  byte_valid,
    output logic                  frame_start,
`ifdef DEMUX_MULTIFRAME_EN
    output logic [3:0]            mf_idx,
    output logic                  mf_start,
`endif
    output logic                  running
);
    localparam int FILL_W = $clog2(STARTUP_BITS + 1);
    typedef enum logic {FILL, RUN} state_t;
    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic              bit_last, slot_last, fill_last;
    assign bit_last  = bit_idx == BIT_W'(BITS_PER_SLOT - 1);
    assign slot_last = slot_idx == SLOT_W'(NUM_SLOTS - 1);
    assign fill_last = fill_cnt == FILL_W'(STARTUP_BITS - 1);
    assign running   = state == RUN;
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= FILL;
            fill_cnt    <= '0;
            bit_idx     <= '0;
            slot_idx    <= '0;
            byte_cnt    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
`ifdef DEMUX_MULTIFRAME_EN
            mf_idx      <= '0;
            mf_start    <= 1'b0;
`endif
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
`ifdef DEMUX_MULTIFRAME_EN
            mf_start    <= 1'b0;
`endif
            if (realign) begin
                state       <= RUN;
                slot_idx    <= '0;
                frame_start <= 1'b1;
                bit_idx     <= bit_en ? BIT_W'(1) : '0;
`ifdef DEMUX_MULTIFRAME_EN
                mf_idx      <= '0;
                mf_start    <= 1'b1;
`endif
            end else if (bit_en) begin
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + FILL_W'(1);
                    if (fill_last) begin
                        state    <= RUN;
                        bit_idx  <= '0;
                        slot_idx <= '0;
                        byte_cnt <= '0;
                    end
                end else if (bit_last) begin
                    bit_idx    <= '0;
                    byte_valid <= 1'b1;
                    byte_cnt   <= byte_cnt + BYTE_CNT_W'(1);
                    if (slot_last) begin
                        slot_idx    <= '0;
                        frame_start <= 1'b1;
`ifdef DEMUX_MULTIFRAME_EN
                        mf_idx      <= mf_idx + 4'd1;
                        mf_start    <= mf_idx == 4'd15;
`endif
                    end else begin
                        slot_idx <= slot_idx + SLOT_W'(1);
                    end
                end else begin
                    bit_idx <= bit_idx + BIT_W'(1);
                end
            end
        end
    end
endmodule
